// File: rtl/core_seq_pkg.sv
// core_seq_pkg: shared sequencer state codes and decoder constants
// Contents: state_t (FSM encoding), ALUOP_/RDSRC_/CSR_ decoder constants,
// is_mem_op() helper that classifies an instruction as a data-memory access.
package core_seq_pkg;
  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;
  localparam logic [3:0] ALUOP_ADD  = 4'd0;
  localparam logic [3:0] ALUOP_SUB  = 4'd1;
  localparam logic [3:0] ALUOP_AND  = 4'd2;
  localparam logic [3:0] ALUOP_OR   = 4'd3;
  localparam logic [3:0] ALUOP_XOR  = 4'd4;
  localparam logic [3:0] ALUOP_SLL  = 4'd5;
  localparam logic [3:0] ALUOP_SRL  = 4'd6;
  localparam logic [3:0] ALUOP_SRA  = 4'd7;
  localparam logic [3:0] ALUOP_SLT  = 4'd8;
  localparam logic [3:0] ALUOP_SLTU = 4'd9;
  localparam logic [1:0] RDSRC_ALU = 2'd0;
  localparam logic [1:0] RDSRC_MEM = 2'd1;
  localparam logic [1:0] RDSRC_PC4 = 2'd2;
  localparam logic [1:0] RDSRC_CSR = 2'd3;
  localparam logic [1:0] CSR_NONE = 2'd0;
  localparam logic [1:0] CSR_RW   = 2'd1;
  localparam logic [1:0] CSR_RS   = 2'd2;
  localparam logic [1:0] CSR_RC   = 2'd3;
  function automatic logic is_mem_op(input logic mem_write, input logic [1:0] rd_src);
    return mem_write || rd_src == RDSRC_MEM;
  endfunction
endpackage

// File: rtl/core_seq_bus_timer.sv
// bus_timer: cycle counter that flags when a memory ack has not arrived in time
// Ports: clk, rst (sync, active-high), clear (zero the count, wins over enable),
// enable (count this cycle), expire (count has reached MEM_TIMEOUT-1).
module bus_timer #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);
  localparam int W = MEM_TIMEOUT > 1 ? $clog2(MEM_TIMEOUT) : 1;
  logic [W-1:0] count;
  always_ff @(posedge clk)
    if (rst || clear) count <= '0;
    else if (enable) count <= count + W'(1);
  assign expire = count == W'(MEM_TIMEOUT - 1);
endmodule

// File: rtl/core_seq.sv
// core_seq: multi-cycle instruction sequencer FETCH/DECODE/EXEC/MEM/WB with bus timeout
// Ports: clk, rst (sync, active-high), run (allow new fetches),
// imem_req/imem_ack/ir_load (instruction fetch), cu_* (decoder fields),
// dmem_req/dmem_we/dmem_ack (data access), rd_we/csr_we/pc_update/instret
// (writeback strobes), state (debug), bus_err (sticky timeout flag).
module core_seq
  import core_seq_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  output logic       imem_req,
  input  logic       imem_ack,
  output logic       ir_load,
  input  logic       cu_rd_write,
  input  logic [1:0] cu_rd_write_src,
  input  logic       cu_mem_write,
  input  logic       cu_csr_wr_en,
  output logic       dmem_req,
  output logic       dmem_we,
  input  logic       dmem_ack,
  output logic       rd_we,
  output logic       csr_we,
  output logic       pc_update,
  output logic       instret,
  output logic [2:0] state,
  output logic       bus_err
);
  state_t cur, nxt;
  logic   err_q, expire, t_clear, t_en;
  always_ff @(posedge clk)
    if (rst) begin
      cur   <= S_FETCH;
      err_q <= 1'b0;
    end else begin
      cur   <= nxt;
      err_q <= err_q || nxt == S_HALT;
    end
  always_comb begin
    nxt       = cur;
    imem_req  = 1'b0;
    ir_load   = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    rd_we     = 1'b0;
    csr_we    = 1'b0;
    pc_update = 1'b0;
    instret   = 1'b0;
    case (cur)
      S_FETCH: begin
        imem_req = run;
        ir_load  = run && imem_ack;
        nxt      = !run ? S_FETCH : imem_ack ? S_DECODE : expire ? S_HALT : S_FETCH;
      end
      S_DECODE: nxt = S_EXEC;
      S_EXEC:   nxt = is_mem_op(cu_mem_write, cu_rd_write_src) ? S_MEM : S_WB;
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = cu_mem_write;
        // an ack in the expiring cycle still completes the access
        nxt      = dmem_ack ? S_WB : expire ? S_HALT : S_MEM;
      end
      S_WB: begin
        rd_we     = cu_rd_write;
        csr_we    = cu_csr_wr_en;
        pc_update = 1'b1;
        instret   = 1'b1;
        nxt       = S_FETCH;
      end
      S_HALT:  nxt = S_HALT;
      default: nxt = S_HALT;
    endcase
  end
  assign t_clear = nxt != cur || (cur == S_FETCH && !run);
  assign t_en    = (cur == S_FETCH && run && !imem_ack) || (cur == S_MEM && !dmem_ack);
  bus_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (t_clear),
    .enable (t_en),
    .expire (expire)
  );
  assign state   = cur;
  assign bus_err = err_q;
endmodule

// File: tb/tb_core_seq.sv
// tb_core_seq: scoreboard bench for core_seq driving fetch/decode/mem scenarios
module tb_core_seq;
  import core_seq_pkg::*;
  localparam logic [8:0] F_IREQ = 9'h100, F_IRL = 9'h080, F_DREQ = 9'h040, F_DWE = 9'h020;
  localparam logic [8:0] F_RDWE = 9'h010, F_CSR = 9'h008, F_PC = 9'h004, F_RET = 9'h002, F_ERR = 9'h001;
  localparam logic [8:0] F_WB = F_PC | F_RET;
  logic       clk = 1'b0, rst, run, imem_req, imem_ack, ir_load;
  logic       cu_rd_write, cu_mem_write, cu_csr_wr_en;
  logic [1:0] cu_rd_write_src;
  logic       dmem_req, dmem_we, dmem_ack, rd_we, csr_we, pc_update, instret, bus_err;
  logic [2:0] state;
  logic [11:0] sb[$];
  int n_chk = 0, n_fail = 0;
  core_seq #(.MEM_TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .run(run), .imem_req(imem_req), .imem_ack(imem_ack),
    .ir_load(ir_load), .cu_rd_write(cu_rd_write), .cu_rd_write_src(cu_rd_write_src),
    .cu_mem_write(cu_mem_write), .cu_csr_wr_en(cu_csr_wr_en), .dmem_req(dmem_req),
    .dmem_we(dmem_we), .dmem_ack(dmem_ack), .rd_we(rd_we), .csr_we(csr_we),
    .pc_update(pc_update), .instret(instret), .state(state), .bus_err(bus_err)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %03h expected %03h", tag, got, exp);
    end
  endtask
  task automatic push(input logic [2:0] st, input logic [8:0] f);
    sb.push_back({st, f});
  endtask
  task automatic tick(input string tag);
    logic [11:0] e;
    @(negedge clk);
    if (sb.size() == 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s: scoreboard empty", tag);
    end else begin
      e = sb.pop_front();
      check(tag, {20'd0, state, imem_req, ir_load, dmem_req, dmem_we, rd_we, csr_we,
                  pc_update, instret, bus_err}, {20'd0, e});
    end
    @(posedge clk);
    #1;
  endtask
  task automatic front(input string tag);
    push(0, F_IREQ | F_IRL); tick({tag, "_f"});
    push(1, 0);              tick({tag, "_d"});
    push(2, 0);              tick({tag, "_x"});
  endtask
  task automatic decode(input logic rdw, input logic [1:0] src, input logic mw, input logic csr);
    cu_rd_write = rdw; cu_rd_write_src = src; cu_mem_write = mw; cu_csr_wr_en = csr;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    rst = 1; run = 0; imem_ack = 0; dmem_ack = 0;
    decode(0, RDSRC_ALU, 0, 0);
    @(posedge clk); #1;
    push(0, 0);      tick("rst_hold");
    rst = 0; run = 1;
    push(0, F_IREQ); tick("rst_run");
    run = 0; imem_ack = 1;
    push(0, 0);      tick("ack_no_req");
    run = 1; imem_ack = 0;
    repeat (3) begin push(0, F_IREQ); tick("fetch_wait"); end
    imem_ack = 1;
    decode(1, RDSRC_ALU, 0, 0);
    front("addi");
    push(4, F_RDWE | F_WB); tick("addi_wb");
    push(0, F_IREQ | F_IRL); tick("addi2_f");
    push(1, 0);             tick("addi2_d");
    run = 0;
    push(2, 0);             tick("addi2_x_norun");
    push(4, F_RDWE | F_WB); tick("addi2_wb");
    repeat (4) begin push(0, 0); tick("idle"); end
    check("cnt_idle", 32'(dut.u_timer.count), 0);
    run = 1;
    decode(1, RDSRC_MEM, 0, 0);
    front("lw");
    run = 0;
    repeat (3) begin push(3, F_DREQ); tick("lw_mem_wait"); end
    dmem_ack = 1;
    push(3, F_DREQ);        tick("lw_mem_ack");
    dmem_ack = 0;
    push(4, F_RDWE | F_WB); tick("lw_wb");
    push(0, 0);             tick("lw_done");
    run = 1; dmem_ack = 1;
    decode(0, RDSRC_ALU, 1, 1);
    front("sw");
    run = 0;
    push(3, F_DREQ | F_DWE); tick("sw_mem");
    push(4, F_CSR | F_WB);   tick("sw_wb");
    push(0, 0);              tick("sw_done");
    dmem_ack = 0; run = 1;
    decode(1, RDSRC_MEM, 0, 0);
    front("late");
    run = 0;
    repeat (15) begin push(3, F_DREQ); tick("late_wait"); end
    dmem_ack = 1;
    push(3, F_DREQ);        tick("late_ack16");
    dmem_ack = 0;
    push(4, F_RDWE | F_WB); tick("late_wb");
    push(0, 0);             tick("late_noerr");
    run = 1;
    front("tmo");
    repeat (16) begin push(3, F_DREQ); tick("tmo_wait"); end
    dmem_ack = 1;
    repeat (3) begin push(5, F_ERR); tick("halt_hold"); end
    dmem_ack = 0; rst = 1;
    push(5, F_ERR); tick("halt_rst");
    rst = 0; run = 0;
    push(0, 0);     tick("after_halt_rst");
    run = 1;
    front("mrst");
    push(3, F_DREQ); tick("mrst_mem");
    rst = 1; run = 0;
    push(3, F_DREQ); tick("mrst_edge");
    rst = 0;
    push(0, 0);      tick("after_mem_rst");
    run = 1; imem_ack = 0;
    repeat (16) begin push(0, F_IREQ); tick("imem_wait"); end
    push(5, F_ERR);  tick("imem_halt");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
